// File: rtl/i2c_bus_event.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_event
// Brief    : Deglitches synchronised SCL/SDA and emits bus events, busy flag
//            and per-bit sample strobes for the I2C byte engines.
// Revision : 1.0
// ============================================================================
module i2c_bus_event #(
    parameter int unsigned FILT_CYCLES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       rstart_det,
    output logic       stop_det,
    output logic       busy,
    output logic       bit_vld,
    output logic       bit_val,
    output logic [3:0] bit_idx
);

    localparam int unsigned FCW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int unsigned TCW = 16;
    localparam logic [FCW-1:0] C_FILT_LAST = FCW'(FILT_CYCLES - 1);
    localparam logic [TCW-1:0] C_TMO_LIMIT = TCW'(TIMEOUT_CYCLES);
    localparam logic [3:0]     C_ACK_IDX   = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Lane 1 is SCL, lane 0 is SDA.
    logic [1:0] line_in;
    logic [1:0] lvl_q;
    logic [1:0] lvl_d;

    assign line_in = {scl_i, sda_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [FCW-1:0] cnt_q;
            logic [FCW-1:0] cnt_d;
            logic           lane_q;
            logic           lane_d;

            always_comb begin
                lane_d = lane_q;
                cnt_d  = '0;
                if (line_in[gi] != lane_q) begin
                    if (cnt_q == C_FILT_LAST) begin
                        lane_d = line_in[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q  <= '0;
                    lane_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_d;
                    lane_q <= lane_d;
                end
            end

            assign lvl_q[gi] = lane_q;
            assign lvl_d[gi] = lane_d;
        end
    endgenerate

    logic scl_q;
    logic sda_q;
    logic scl_d;
    logic sda_d;

    assign scl_q = lvl_q[1];
    assign sda_q = lvl_q[0];
    assign scl_d = lvl_d[1];
    assign sda_d = lvl_d[0];

    // Events are decoded from the next filtered levels so the registered
    // pulses line up with the first cycle showing the new level.
    logic ev_scl_rise;
    logic ev_scl_fall;
    logic ev_start;
    logic ev_stop;

    assign ev_scl_rise = ~scl_q &  scl_d;
    assign ev_scl_fall =  scl_q & ~scl_d;
    assign ev_start    =  scl_q &  scl_d &  sda_q & ~sda_d;
    assign ev_stop     =  scl_q &  scl_d & ~sda_q &  sda_d;

    state_t         state_q;
    logic [TCW-1:0] tmo_cnt_q;
    logic [TCW-1:0] tmo_cnt_d;
    logic           tmo_hit;
    logic           scl_rise_q;
    logic           scl_fall_q;
    logic           start_q;
    logic           rstart_q;
    logic           stop_q;
    logic           busy_q;
    logic           bit_vld_q;
    logic           bit_val_q;
    logic [3:0]     idx_q;

    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if ((TIMEOUT_CYCLES != 0) && (state_q == ST_BUSY) && scl_q && sda_q) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            tmo_hit   = (tmo_cnt_d == C_TMO_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmo_cnt_q  <= '0;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            bit_vld_q  <= 1'b0;
            bit_val_q  <= 1'b0;
            idx_q      <= 4'd0;
        end else begin
            scl_rise_q <= ev_scl_rise;
            scl_fall_q <= ev_scl_fall;
            start_q    <= ev_start;
            stop_q     <= ev_stop;
            rstart_q   <= ev_start && (state_q == ST_BUSY);
            bit_vld_q  <= ev_scl_rise && (state_q == ST_BUSY);
            if (ev_scl_rise && (state_q == ST_BUSY)) begin
                bit_val_q <= sda_d;
            end

            // The index shown with a bit strobe advances on the following cycle.
            if (ev_start) begin
                idx_q <= 4'd0;
            end else if (bit_vld_q) begin
                idx_q <= (idx_q == C_ACK_IDX) ? 4'd0 : idx_q + 4'd1;
            end

            tmo_cnt_q <= tmo_hit ? '0 : tmo_cnt_d;

            case (state_q)
                ST_IDLE: begin
                    if (ev_start) begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (ev_stop || (tmo_hit && !ev_start)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scl_f      = scl_q;
    assign sda_f      = sda_q;
    assign scl_rise   = scl_rise_q;
    assign scl_fall   = scl_fall_q;
    assign start_det  = start_q;
    assign rstart_det = rstart_q;
    assign stop_det   = stop_q;
    assign busy       = busy_q;
    assign bit_vld    = bit_vld_q;
    assign bit_val    = bit_val_q;
    assign bit_idx    = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_event
// Brief    : Directed bench for i2c_bus_event with a bit-strobe scoreboard.
// Revision : 1.0
// ============================================================================
module tb_i2c_bus_event;

    logic       clk;
    logic       rst_n;
    logic       scl_i;
    logic       sda_i;
    logic       scl_f;
    logic       sda_f;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       rstart_det;
    logic       stop_det;
    logic       busy;
    logic       bit_vld;
    logic       bit_val;
    logic [3:0] bit_idx;

    i2c_bus_event #(
        .FILT_CYCLES    (3),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .rstart_det (rstart_det),
        .stop_det   (stop_det),
        .busy       (busy),
        .bit_vld    (bit_vld),
        .bit_val    (bit_val),
        .bit_idx    (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic       val;
    } bit_t;

    bit_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   start_cnt = 0;
    int   rstart_cnt = 0;
    int   stop_cnt = 0;
    int   bit_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pushes the expected strobe, then clocks one bit with ample filter settle time.
    task automatic send_bit(input logic b, input logic [3:0] idx);
        bit_t e;
        scl_i = 1'b0;
        tick(4);
        sda_i = b;
        tick(4);
        e.idx = idx;
        e.val = b;
        exp_q.push_back(e);
        scl_i = 1'b1;
        tick(4);
    endtask

    // Monitor samples shortly after each rising edge, away from the stimulus edge.
    always @(posedge clk) begin
        bit_t e;
        #2;
        if (rst_n) begin
            if (scl_rise)   rise_cnt++;
            if (scl_fall)   fall_cnt++;
            if (start_det)  start_cnt++;
            if (stop_det)   stop_cnt++;
            if (rstart_det) begin
                rstart_cnt++;
                check("rstart_with_start", {31'd0, start_det}, 32'd1);
            end
            if (bit_vld) begin
                bit_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit_vld", {31'd0, bit_vld}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_idx", {28'd0, bit_idx}, {28'd0, e.idx});
                    check("bit_val", {31'd0, bit_val}, {31'd0, e.val});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi_cnt;
        int stop_before;
        logic [7:0] byte_v;

        rst_n = 1'b0;
        scl_i = 1'b0;
        sda_i = 1'b0;
        tick(4);
        check("rst_scl_f", {31'd0, scl_f}, 32'd1);
        check("rst_sda_f", {31'd0, sda_f}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bit_idx", {28'd0, bit_idx}, 32'd0);
        check("rst_pulses", {26'd0, scl_rise, scl_fall, start_det, stop_det, rstart_det, bit_vld}, 32'd0);

        rst_n = 1'b1;
        tick(2);
        check("rel_scl_f_hold", {31'd0, scl_f}, 32'd1);
        tick(1);
        check("rel_scl_f_fall", {31'd0, scl_f}, 32'd0);
        check("rel_sda_f_fall", {31'd0, sda_f}, 32'd0);
        tick(1);

        // Both lines return high together: SCL edge only, no STOP.
        scl_i = 1'b1;
        sda_i = 1'b1;
        tick(5);
        check("same_cyc_rise_cnt", rise_cnt, 32'd1);
        check("same_cyc_fall_cnt", fall_cnt, 32'd1);
        check("same_cyc_no_start", start_cnt, 32'd0);
        check("same_cyc_no_stop", stop_cnt, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Short SDA glitch is rejected.
        sda_i = 1'b0;
        tick(2);
        sda_i = 1'b1;
        tick(3);
        check("glitch_sda_f", {31'd0, sda_f}, 32'd1);
        check("glitch_no_start", start_cnt, 32'd0);

        sda_i = 1'b0;
        tick(3);
        check("start_det", {31'd0, start_det}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_no_rstart", {31'd0, rstart_det}, 32'd0);
        check("start_bit_idx", {28'd0, bit_idx}, 32'd0);
        tick(1);
        check("start_one_cycle", {31'd0, start_det}, 32'd0);

        byte_v = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(byte_v[7-i], 4'(i));
        send_bit(1'b0, 4'd8);
        tick(2);
        check("byte_bit_cnt", bit_cnt, 32'd9);
        check("byte_idx_wrap", {28'd0, bit_idx}, 32'd0);

        // Bits 0..3, last one high so SDA can fall for the repeated START.
        send_bit(1'b1, 4'd0);
        send_bit(1'b0, 4'd1);
        send_bit(1'b0, 4'd2);
        send_bit(1'b1, 4'd3);
        sda_i = 1'b0;
        tick(3);
        check("rs_start_det", {31'd0, start_det}, 32'd1);
        check("rs_rstart_det", {31'd0, rstart_det}, 32'd1);
        check("rs_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("rs_bit_idx", {28'd0, bit_idx}, 32'd0);
        send_bit(1'b0, 4'd0);
        send_bit(1'b1, 4'd1);

        scl_i = 1'b0;
        tick(4);
        sda_i = 1'b0;
        tick(4);
        begin
            bit_t e;
            e.idx = 4'd2;
            e.val = 1'b0;
            exp_q.push_back(e);
        end
        scl_i = 1'b1;
        tick(4);
        sda_i = 1'b1;
        tick(3);
        check("stop_det", {31'd0, stop_det}, 32'd1);
        check("stop_busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("stop_one_cycle", {31'd0, stop_det}, 32'd0);
        check("stop_cnt", stop_cnt, 32'd1);

        // Busy without STOP, then lines idle high until the timeout fires.
        sda_i = 1'b0;
        tick(3);
        check("t_start_no_rstart", {31'd0, rstart_det}, 32'd0);
        check("t_busy", {31'd0, busy}, 32'd1);
        scl_i = 1'b0;
        tick(4);
        sda_i = 1'b1;
        tick(4);
        begin
            bit_t e;
            e.idx = 4'd0;
            e.val = 1'b1;
            exp_q.push_back(e);
        end
        stop_before = stop_cnt;
        scl_i = 1'b1;
        hi_cnt = 0;
        for (int c = 0; c < 250; c++) begin
            tick(1);
            if (!busy) break;
            if (scl_f && sda_f) hi_cnt++;
        end
        check("timeout_cycles", hi_cnt, 32'd100);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_no_stop", stop_cnt, stop_before);

        // Reset mid-byte returns everything at once.
        sda_i = 1'b0;
        tick(3);
        check("m_busy", {31'd0, busy}, 32'd1);
        send_bit(1'b1, 4'd0);
        send_bit(1'b0, 4'd1);
        scl_i = 1'b0;
        tick(4);
        check("m_idx_before", {28'd0, bit_idx}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("m_rst_busy", {31'd0, busy}, 32'd0);
        check("m_rst_idx", {28'd0, bit_idx}, 32'd0);
        check("m_rst_scl_f", {31'd0, scl_f}, 32'd1);
        tick(3);
        scl_i = 1'b1;
        sda_i = 1'b1;
        rst_n = 1'b1;
        tick(5);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_rstart_cnt", rstart_cnt, 32'd1);
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
